// File: rtl/cpu_timer.sv
// Loadable down-counting interval timer with sticky level interrupt and overrun flag.
// One-shot or periodic auto-reload; counts from the reload value down to zero.
module cpu_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             periodic_i,
    input  logic             ack_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             irq_o,
    output logic             overrun_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rld;
    logic [WIDTH-1:0] count;
    logic             irq;
    logic             overrun;

    logic [WIDTH-1:0] start_val;
    logic             expiry;

    // A start in the same cycle as a load uses the value being loaded.
    always_comb begin
        start_val = load_i ? load_val_i : rld;
        expiry    = (state == RUN) && !stop_i && (count == WIDTH'(1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            rld     <= '0;
            count   <= '0;
            irq     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load_i)
                rld <= load_val_i;

            case (state)
                RUN: begin
                    if (stop_i) begin
                        state <= IDLE;
                    end else if (expiry) begin
                        // Reload uses the rld held before any same-cycle load.
                        if (periodic_i && (rld != '0)) begin
                            count <= rld;
                        end else begin
                            count <= '0;
                            state <= DONE;
                        end
                    end else if (count != '0) begin
                        count <= count - WIDTH'(1);
                    end
                end
                default: begin
                    if (stop_i) begin
                        state <= IDLE;
                    end else if (start_i && (start_val != '0)) begin
                        count <= start_val;
                        state <= RUN;
                    end else if (load_i) begin
                        count <= load_val_i;
                    end
                end
            endcase

            // Later assignments win: an expiry re-arms irq even under ack.
            if (expiry && irq && !ack_i)
                overrun <= 1'b1;
            if (ack_i) begin
                irq     <= 1'b0;
                overrun <= 1'b0;
            end
            if (expiry)
                irq <= 1'b1;
        end
    end

    assign count_o   = count;
    assign busy_o    = (state == RUN);
    assign irq_o     = irq;
    assign overrun_o = overrun;

endmodule

// File: doc/cpu_timer.md
Name: cpu_timer

Overview:
- Loadable down-counting interval timer. It is the counterpart to the free-running 4-bit up-counter: software programs a reload value, and the block counts down to zero.
- On expiry it raises a level interrupt that is held until acknowledged.
- Sits beside the up-counter under cpu_top. It gives the CPU core one-shot and periodic tick events.

Parameters:
- WIDTH, 4, width of the count and reload registers (matches the 4-bit counter).

Ports:
- clk_i  input  1  clock; all logic is on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- load_i  input  1  write load_val_i into the reload register.
- load_val_i  input  WIDTH  reload value.
- start_i  input  1  start counting.
- stop_i  input  1  abort counting.
- periodic_i  input  1  1 = auto-reload on expiry; 0 = one-shot. Sampled at each expiry.
- ack_i  input  1  interrupt acknowledge.
- count_o  output  WIDTH  current count.
- busy_o  output  1  high while in RUN.
- irq_o  output  1  expiry interrupt, level, sticky.
- overrun_o  output  1  expiry occurred while irq_o was already pending and unacknowledged. Sticky.

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE; rld=0; count_o=0; busy_o=0; irq_o=0; overrun_o=0. Reset overrides all other inputs, including mid-count.
- Registers: rld (WIDTH), count (WIDTH), 2-bit state (IDLE, RUN, DONE), irq, overrun. All outputs are registered, and busy_o = (state==RUN).
- Priority within one cycle is stop_i > load_i/start_i > expiry.
- load_i:
  - In any state: rld <= load_val_i.
  - In IDLE/DONE: count <= load_val_i as well.
  - In RUN: count is unaffected; the new rld takes effect at the next reload.
- IDLE/DONE with start_i=1: the effective reload value is load_val_i if load_i=1 in the same cycle, else rld.
  - If the effective value != 0: count <= that value, go to RUN.
  - If the effective value == 0: start is ignored; no state change, no irq.
- RUN, with stop_i=0:
  - If count != 1: count <= count-1.
  - If count == 1, this is an expiry:
    - irq set.
    - If periodic_i=1: count <= rld, stay in RUN. If rld==0 at that moment, count <= 0 and go to DONE.
    - If periodic_i=0: count <= 0, go to DONE.
  - count never wraps below 0.
  - start_i in RUN is ignored.
- RUN with stop_i=1: go to IDLE, count holds its current value, no expiry or irq that cycle even if count==1.
- Timing: if start is sampled at edge N with reload value R, count_o=R after edge N and irq_o=1 after edge N+R. Periodic mode gives one expiry every R cycles; R=1 gives an expiry every cycle.
- DONE: count_o=0 and busy_o=0. stop_i goes to IDLE. start_i behaves as in IDLE.
- irq and overrun, evaluated each edge in this order:
  - If expiry and irq=1 and ack_i=0: overrun <= 1.
  - If ack_i=1: irq <= 0 and overrun <= 0.
  - If expiry: irq <= 1. Set wins over ack in the same cycle, and overrun is not set because the ack consumes the old event.
- ack_i with irq_o=0 has no effect.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles, then no stimulus for 10 cycles -> count_o=0, busy_o=0, irq_o=0, overrun_o=0 throughout.
- One-shot:
  - Stimulus: load_i with load_val_i=5, then start_i at edge N.
  - Required count_o after edges N..N+5: 5,4,3,2,1,0.
  - irq_o=1 and busy_o=0 from edge N+5.
  - ack_i at N+8 -> irq_o=0 after N+8.
- Periodic with overrun:
  - Stimulus: load 3, periodic_i=1, start; no ack.
  - Required: count cycles 3,2,1,3,2,1…; irq_o=1 after the first expiry; overrun_o=1 after the second.
  - ack_i alone clears both.
  - ack_i on the same cycle as an expiry -> irq_o stays 1, overrun_o stays 0.
- Stop mid-count: load 9, start, stop_i after count_o=6 -> IDLE, count_o holds 6, no irq. Then start -> count_o=9.
- Simultaneous events:
  - load_i(val=2)+start_i in the same IDLE cycle -> count_o=2, irq after 2 cycles.
  - stop_i when count_o=1 -> no irq.
  - start with rld=0 -> stays IDLE.
  - load 15 -> full-width count 15..0 with no wrap.
- Reset mid-operation: periodic run with rld=4 and irq pending; rst_i=1 at any cycle -> all outputs 0 next edge, rld=0, and a subsequent start is ignored until a load.
